// File: rtl/peri_uart_fifo.sv
// -----------------------------------------------------------------------------
// peri_uart_fifo
//
// Bus-side UART register block. It buffers bytes in both directions between the
// 64-bit peripheral bus and the byte-level uart core. The uart core runs on the
// same clock as this block.
//
// Register map (byte addresses, full 32-bit match):
//   BASE_ADDR+0   DR  read pops the RX head; write (lane 0) pushes to TX
//   BASE_ADDR+8   SR  read-only status:
//                     {tx_count, rx_count, rx_overrun, tx_full, tx_empty,
//                      rx_full, rx_nempty}
//   BASE_ADDR+16  CR  bit0 rxie, bit1 txie (optional), bit2 ovclr (write-1)
//
// Optional feature (build macro SOC2_PERI_UART_TXINT_EN):
//   When the macro is defined, CR bit1 (txie) is stored and the term
//   txie & tx_empty raises uart_intr. When the macro is undefined, CR bit1
//   reads 0 and has no effect.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   rdaddress/rden  read request; rdata is valid one cycle later
//   wraddress/wdata/wrbyteena/wren
//                   write request
//   tx_data/tx_data_valid/tx_data_ack
//                   TX FIFO head offered to the uart core
//   rx_data/rx_data_fresh
//                   received byte from the uart core
//   uart_intr       registered level interrupt
// -----------------------------------------------------------------------------
module peri_uart_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rdaddress,
    input  logic        rden,
    output logic [63:0] rdata,
    input  logic [31:0] wraddress,
    input  logic [63:0] wdata,
    input  logic [7:0]  wrbyteena,
    input  logic        wren,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_fresh,
    output logic        uart_intr
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_CW = TX_AW + 1;

    localparam logic [31:0] DR_ADDR = BASE_ADDR;
    localparam logic [31:0] SR_ADDR = BASE_ADDR + 32'd8;
    localparam logic [31:0] CR_ADDR = BASE_ADDR + 32'd16;

    // ------------------------------------------------------------------
    // Storage and registered state
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       tx_mem_q [TX_DEPTH];

    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d;
    logic [RX_AW-1:0] rx_rptr_q, rx_rptr_d;
    logic [RX_CW-1:0] rx_cnt_q,  rx_cnt_d;
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d;
    logic [TX_AW-1:0] tx_rptr_q, tx_rptr_d;
    logic [TX_CW-1:0] tx_cnt_q,  tx_cnt_d;
    logic             ovr_q,     ovr_d;
    logic             rxie_q,    rxie_d;
    logic             intr_q,    intr_d;
    logic [63:0]      rdata_q,   rdata_d;
    logic             txie;
    logic             txie_d;

`ifdef SOC2_PERI_UART_TXINT_EN
    logic             txie_q;
    assign txie = txie_q;
`else
    assign txie = 1'b0;
`endif

    // Bus bits that carry no meaning for this block.
    logic unused_bus;
    assign unused_bus = ^{wdata[63:8], wrbyteena[7:1]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic rd_dr, rd_sr, rd_cr;
    logic wr_dr, wr_cr;

    assign rd_dr = rden && (rdaddress == DR_ADDR);
    assign rd_sr = rden && (rdaddress == SR_ADDR);
    assign rd_cr = rden && (rdaddress == CR_ADDR);
    assign wr_dr = wren && wrbyteena[0] && (wraddress == DR_ADDR);
    assign wr_cr = wren && wrbyteena[0] && (wraddress == CR_ADDR);

    // ------------------------------------------------------------------
    // FIFO flags (from registered state)
    // ------------------------------------------------------------------
    logic rx_empty, rx_full, tx_empty, tx_full;

    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));

    // ------------------------------------------------------------------
    // Push / pop qualification
    // ------------------------------------------------------------------
    logic rx_pop, rx_push, rx_ovf;
    logic tx_pop, tx_push;

    assign rx_pop  = rd_dr && !rx_empty;
    // A full RX FIFO still accepts a byte if a DR read frees a slot this cycle.
    assign rx_push = rx_data_fresh && (!rx_full || rx_pop);
    assign rx_ovf  = rx_data_fresh && rx_full && !rx_pop;

    // TX fullness is judged before the ack, so a push into a full FIFO is
    // dropped even when the core consumes the head in the same cycle.
    assign tx_push = wr_dr && !tx_full;
    assign tx_pop  = tx_data_ack && !tx_empty;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [63:0] sr_val;
    logic [63:0] cr_val;

    assign sr_val = {40'h0, 8'(tx_cnt_q), 8'(rx_cnt_q), 3'b000,
                     ovr_q, tx_full, tx_empty, rx_full, !rx_empty};
    assign cr_val = {61'h0, 1'b0, txie, rxie_q};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        ovr_d     = ovr_q;
        rxie_d    = rxie_q;
        txie_d    = txie;
        rdata_d   = 64'h0;
        intr_d    = 1'b0;

        if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
        if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + RX_CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - RX_CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
        if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + TX_CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - TX_CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (wr_cr) begin
            rxie_d = wdata[0];
`ifdef SOC2_PERI_UART_TXINT_EN
            txie_d = wdata[1];
`endif
            if (wdata[2]) ovr_d = 1'b0;
        end
        // A fresh overrun beats a same-cycle clear.
        if (rx_ovf) ovr_d = 1'b1;

        if (rd_dr && !rx_empty) rdata_d = {56'h0, rx_mem_q[rx_rptr_q]};
        else if (rd_sr)         rdata_d = sr_val;
        else if (rd_cr)         rdata_d = cr_val;

        // Interrupt follows the post-update state so it appears one cycle
        // after its cause.
        intr_d = rxie_d && ((rx_cnt_d != '0) || ovr_d);
`ifdef SOC2_PERI_UART_TXINT_EN
        intr_d = intr_d || (txie_d && (tx_cnt_d == '0));
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            ovr_q     <= 1'b0;
            rxie_q    <= 1'b0;
            intr_q    <= 1'b0;
            rdata_q   <= 64'h0;
        end else begin
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_cnt_q  <= tx_cnt_d;
            ovr_q     <= ovr_d;
            rxie_q    <= rxie_d;
            intr_q    <= intr_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef SOC2_PERI_UART_TXINT_EN
    always_ff @(posedge clk) begin
        if (rst) txie_q <= 1'b0;
        else     txie_q <= txie_d;
    end
`else
    logic unused_txie;
    assign unused_txie = txie_d;
`endif

    // Data arrays carry no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data;
        if (tx_push) tx_mem_q[tx_wptr_q] <= wdata[7:0];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata         = rdata_q;
    assign tx_data       = tx_mem_q[tx_rptr_q];
    assign tx_data_valid = !tx_empty;
    assign uart_intr     = intr_q;

endmodule

// File: tb/tb_peri_uart_fifo.sv
module tb_peri_uart_fifo;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam logic [31:0] DR   = BASE;
    localparam logic [31:0] SR   = BASE + 32'd8;
    localparam logic [31:0] CR   = BASE + 32'd16;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rdaddress = '0;
    logic        rden = 1'b0;
    logic [63:0] rdata;
    logic [31:0] wraddress = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wrbyteena = '0;
    logic        wren = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_data_fresh = 1'b0;
    logic        uart_intr;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [63:0] rv;
    logic [7:0]  expb;

    always #5 clk = ~clk;

    peri_uart_fifo dut (
        .clk(clk), .rst(rst),
        .rdaddress(rdaddress), .rden(rden), .rdata(rdata),
        .wraddress(wraddress), .wdata(wdata), .wrbyteena(wrbyteena), .wren(wren),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ack(tx_data_ack),
        .rx_data(rx_data), .rx_data_fresh(rx_data_fresh),
        .uart_intr(uart_intr)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the DUT samples on the next rising
    // edge and results are inspected at the following falling edge.
    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
        wraddress = a; wdata = d; wrbyteena = be; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0; wrbyteena = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [63:0] d);
        rdaddress = a; rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        d = rdata;
    endtask

    task automatic ack();
        tx_data_ack = 1'b1;
        @(negedge clk);
        tx_data_ack = 1'b0;
    endtask

    task automatic fresh(input logic [7:0] b);
        rx_data = b; rx_data_fresh = 1'b1;
        @(negedge clk);
        rx_data_fresh = 1'b0;
    endtask

    // Model-side push into the expected RX stream.
    task automatic rx_model_push(input logic [7:0] b, inout logic ovr);
        if (rxq.size() < DEPTH) rxq.push_back(b);
        else ovr = 1'b1;
    endtask

    task automatic tx_write(input logic [7:0] b);
        if (txq.size() < DEPTH) txq.push_back(b);
        wr(DR, {56'hFFFF_FFFF_FFFF_FF, b}, 8'hFF);
    endtask

    initial begin
        logic ovr_m;
        ovr_m = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_intr", {63'h0, uart_intr}, 64'h0);
        chk("rst_txvalid", {63'h0, tx_data_valid}, 64'h0);
        rd(SR, rv);
        chk("rst_sr", rv, 64'h4);
        @(negedge clk);
        chk("rdata_idle", rdata, 64'h0);

        // TX ordering
        tx_write(8'h41); tx_write(8'h42); tx_write(8'h43);
        rd(SR, rv);
        chk("tx_sr3", rv, 64'h0000_0000_0003_0000);
        for (int i = 0; i < 3; i++) begin
            chk("tx_valid", {63'h0, tx_data_valid}, 64'h1);
            expb = txq.pop_front();
            chk("tx_data", {56'h0, tx_data}, {56'h0, expb});
            ack();
        end
        chk("tx_valid_fall", {63'h0, tx_data_valid}, 64'h0);
        ack();
        rd(SR, rv);
        chk("tx_sr0", rv, 64'h4);

        // Lane gating and non-hit addresses
        wr(DR, 64'h55, 8'hFE);
        chk("dr_be0_off", {63'h0, tx_data_valid}, 64'h0);
        wr(BASE + 32'd4, 64'h77, 8'hFF);
        chk("wr_nohit", {63'h0, tx_data_valid}, 64'h0);
        rd(BASE + 32'd24, rv);
        chk("rd_nohit", rv, 64'h0);

        // RX single byte and interrupt
        wr(CR, 64'h1, 8'h01);
        rd(CR, rv);
        chk("cr_rb1", rv, 64'h1);
        chk("intr_idle", {63'h0, uart_intr}, 64'h0);
        fresh(8'h5A); rx_model_push(8'h5A, ovr_m);
        chk("intr_rx", {63'h0, uart_intr}, 64'h1);
        rd(DR, rv);
        expb = rxq.pop_front();
        chk("rx_dr", rv, {56'h0, expb});
        chk("intr_clr", {63'h0, uart_intr}, 64'h0);
        rd(DR, rv);
        chk("rx_empty_rd", rv, 64'h0);

        // RX overrun
        for (int i = 0; i < DEPTH + 1; i++) begin
            fresh(8'h10 + 8'(i));
            rx_model_push(8'h10 + 8'(i), ovr_m);
        end
        rd(SR, rv);
        chk("ovr_sr", rv, {48'h0, 8'(rxq.size()), 3'b0, ovr_m, 4'b0111});
        chk("ovr_sr_const", rv, 64'h0000_0000_0000_1017);
        chk("ovr_intr", {63'h0, uart_intr}, 64'h1);
        while (rxq.size() > 0) begin
            rd(DR, rv);
            expb = rxq.pop_front();
            chk("ovr_drain", rv, {56'h0, expb});
        end
        rd(SR, rv);
        chk("ovr_sticky", rv, 64'h14);
        chk("ovr_intr_hold", {63'h0, uart_intr}, 64'h1);
        wr(CR, 64'h4, 8'h01);
        ovr_m = 1'b0;
        chk("ovclr_intr", {63'h0, uart_intr}, 64'h0);
        rd(SR, rv);
        chk("ovclr_sr", rv, 64'h4);
        rd(CR, rv);
        chk("cr_rb_ovclr", rv, 64'h0);

        // Full RX with simultaneous read and fresh byte
        for (int i = 0; i < DEPTH; i++) begin
            fresh(8'hA0 + 8'(i));
            rx_model_push(8'hA0 + 8'(i), ovr_m);
        end
        rdaddress = DR; rden = 1'b1; rx_data = 8'hEE; rx_data_fresh = 1'b1;
        @(negedge clk);
        rden = 1'b0; rx_data_fresh = 1'b0;
        expb = rxq.pop_front();
        rxq.push_back(8'hEE);
        chk("sim_rd", rdata, {56'h0, expb});
        rd(SR, rv);
        chk("sim_sr", rv, 64'h0000_0000_0000_1007);
        while (rxq.size() > 0) begin
            rd(DR, rv);
            expb = rxq.pop_front();
            chk("sim_drain", rv, {56'h0, expb});
        end

        // TX full: drop on overflow and on push-while-full with ack
        for (int i = 0; i < DEPTH + 1; i++) tx_write(8'h60 + 8'(i));
        rd(SR, rv);
        chk("txfull_sr", rv, 64'h0000_0000_0010_0008);
        chk("txfull_head", {56'h0, tx_data}, {56'h0, txq[0]});
        wraddress = DR; wdata = 64'h71; wrbyteena = 8'h01; wren = 1'b1; tx_data_ack = 1'b1;
        @(negedge clk);
        wren = 1'b0; tx_data_ack = 1'b0;
        void'(txq.pop_front());
        rd(SR, rv);
        chk("txfull_pp_sr", rv, 64'h0000_0000_000F_0000);
        while (txq.size() > 0) begin
            expb = txq.pop_front();
            chk("txfull_drain", {56'h0, tx_data}, {56'h0, expb});
            ack();
        end
        chk("txfull_empty", {63'h0, tx_data_valid}, 64'h0);

        // Optional TX-empty interrupt
        wr(CR, 64'h2, 8'h01);
        rd(CR, rv);
`ifdef SOC2_PERI_UART_TXINT_EN
        chk("txie_rb", rv, 64'h2);
        chk("txie_intr", {63'h0, uart_intr}, 64'h1);
        tx_write(8'h99);
        chk("txie_intr_off", {63'h0, uart_intr}, 64'h0);
`else
        chk("txie_rb", rv, 64'h0);
        chk("txie_intr", {63'h0, uart_intr}, 64'h0);
        tx_write(8'h99);
        chk("txie_intr_off", {63'h0, uart_intr}, 64'h0);
`endif
        wr(CR, 64'h0, 8'h01);

        // Reset mid-transfer flushes both FIFOs; ack during reset ignored
        tx_write(8'h01);
        fresh(8'h03);
        rst = 1'b1; tx_data_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; tx_data_ack = 1'b0;
        txq.delete(); rxq.delete();
        chk("rst2_txvalid", {63'h0, tx_data_valid}, 64'h0);
        chk("rst2_intr", {63'h0, uart_intr}, 64'h0);
        rd(SR, rv);
        chk("rst2_sr", rv, 64'h4);
        tx_write(8'hC3);
        expb = txq.pop_front();
        chk("rst2_tx_first", {56'h0, tx_data}, {56'h0, expb});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
